uart_tx_buf: RTL
================

Name: uart_tx_buf

Overview:
- Bus-slave transmit buffer placed between interconnect slave port 2 (UART window, 0x2000_0000) and the existing `uart` transmitter.
- Firmware writes bytes at bus speed. The block queues them in a FIFO and feeds them one at a time over the transmitter's sendData/sendReq/ready handshake.
- Exposes a status register, a sticky overflow flag, flush control and a low-watermark interrupt, so cores no longer spin on tx_ready per byte.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- LOW_WM, 4, irq_o asserts when fill count ≤ LOW_WM and irq enabled.
- CNT_BITS, $clog2(DEPTH)+1, width of fill count.

Ports:
- clk  in  1  single system clock
- rst  in  1  asynchronous, active-high reset
- bus_req  in  1  slave request (interconnect slave_data_req)
- bus_we  in  1  write enable
- bus_addr  in  4  byte offset within window
- bus_wdata  in  32  write data
- bus_be  in  4  byte enables
- bus_rdata  out  32  read data, combinational, valid in the req cycle
- tx_data  out  8  byte to transmitter (sendData)
- tx_req  out  1  one-cycle send pulse (sendReq)
- tx_ready  in  1  transmitter idle
- irq_o  out  1  level interrupt

Behaviour:
- Register map (word offsets):
  - 0x0 TXDATA: write with be[0]=1 pushes wdata[7:0]; read returns STATUS.
  - 0x4 STATUS (read-only): [0] empty, [1] full, [2] overflow, [3] busy (FSM≠IDLE), [4] irq_en, [8 +: CNT_BITS] count.
  - 0x8 CTRL: write bit0=1 clears overflow; bit1=1 flushes FIFO; bit2 sets irq_en (written value). Read returns {29'b0, irq_en, 2'b0}.
  - Other offsets: writes ignored; reads return 0.
- Bus timing: no wait states (gnt/rvalid tied high upstream); rdata reflects state before the current cycle's edge.
- Reset: FIFO empty, count=0, overflow=0, irq_en=0, FSM=IDLE, tx_req=0, tx_data=0, irq_o=0.
- Push rules:
  - Push accepted if count<DEPTH, or a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
  - Push and pop in the same cycle leave count unchanged.
- FSM (tx_req and tx_data are registered):
  - IDLE: if count>0 and tx_ready=1, pop the head into tx_data, pulse tx_req for one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_ready=0 (transmitter accepted), then go to WAIT_DONE. After 4 cycles with tx_ready still 1, return to IDLE; the byte counts as sent.
  - WAIT_DONE: wait for tx_ready=1, then go to IDLE.
- Latency: write to an empty FIFO with tx_ready=1 at edge N gives tx_req=1 during cycle N+1. Back-to-back bytes restart no earlier than the cycle after tx_ready returns high.
- Flush: clears pointers and count. It does not affect a byte already handed over; the FSM completes normally. Flush and push in the same cycle: flush wins and the push is discarded without setting overflow.
- Overflow clear and a dropped push in the same cycle: overflow ends at 1.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH or goes below 0.
- irq_o = irq_en & (count ≤ LOW_WM), registered one cycle after count changes.
- rst asserted mid-transmission: all state returns to reset values immediately; the transmitter finishes its own frame independently.

Decomposition:
- Package uart_tx_buf_pkg: register offsets (TXDATA/STATUS/CTRL), STATUS/CTRL bit positions, FSM state encoding (IDLE, WAIT_BUSY, WAIT_DONE), WAIT_BUSY timeout constant (4).
- Sub-module sync_fifo (DATA_W=8, DEPTH): push/pop/flush, full/empty/count, same-cycle push+pop when full allowed.
- Top: bus decode, FSM, flags.

Test Plan:
- Reset, then read STATUS -> 0x0000_0001 (empty); tx_req=0; irq_o=0.
- Write 0x41,0x42,0x43 to 0x0 with tx_ready model (1 idle, 0 for 10 cycles after tx_req) -> exactly three tx_req pulses with tx_data 0x41,0x42,0x43 in order; first pulse the cycle after the first write.
- Hold tx_ready=0 and write 17 bytes with DEPTH=16 -> STATUS full=1, count=16, overflow=1; write 0x1 to 0x8 -> overflow=0, FIFO intact.
- Full FIFO, tx_ready rising so a pop coincides with a push -> push accepted, count stays 16, overflow stays 0.
- Queue 8 bytes, flush via CTRL bit1 while a byte is in flight -> in-flight byte completes, no further tx_req, count=0.
- Write CTRL=0x4, fill to 8 bytes, drain -> irq_o=0 while count>4; irq_o=1 one cycle after count reaches 4; assert rst mid-drain -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_tx_buf_pkg.sv
// Shared constants for the UART transmit buffer.
// Holds the register offsets, STATUS/CTRL bit positions, FSM state encoding
// and the WAIT_BUSY timeout.
package uart_tx_buf_pkg;

  // Register offsets within the UART window
  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  // STATUS bit positions
  localparam int unsigned ST_EMPTY  = 0;
  localparam int unsigned ST_FULL   = 1;
  localparam int unsigned ST_OVF    = 2;
  localparam int unsigned ST_BUSY   = 3;
  localparam int unsigned ST_IRQ_EN = 4;
  localparam int unsigned ST_COUNT  = 8;

  // CTRL bit positions
  localparam int unsigned CTRL_OVF_CLR = 0;
  localparam int unsigned CTRL_FLUSH   = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;

  // Transmit FSM state encoding
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  // Cycles WAIT_BUSY tolerates tx_ready staying high before assuming the byte went out
  localparam int unsigned BUSY_TIMEOUT = 4;
  localparam int unsigned TMO_W        = 2;

endpackage

// File: rtl/uart_tx_buf_fifo.sv
// Synchronous FIFO with flush, count and same-cycle push+pop when full.
// Ports:
//   clk, rst         clock, async active-high reset
//   push, push_data  write request and data
//   pop              read request (ignored when empty)
//   flush            clear pointers and count; wins over push
//   head_c           data at read pointer (combinational)
//   full_c, empty_c  occupancy flags (combinational from count)
//   push_ok_c        push is accepted this cycle
//   count            fill count (registered)
module sync_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [DATA_W-1:0]   push_data,
  input  logic                pop,
  input  logic                flush,
  output logic [DATA_W-1:0]   head_c,
  output logic                full_c,
  output logic                empty_c,
  output logic                push_ok_c,
  output logic [CNT_BITS-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;

  assign full_c    = (count == CNT_BITS'(DEPTH));
  assign empty_c   = (count == '0);
  assign do_pop    = pop & ~empty_c;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign push_ok_c = push & ~flush & (~full_c | do_pop);
  assign head_c    = mem[rd_ptr];

  // Storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

  // Pointers and count; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_BITS'(push_ok_c) - CNT_BITS'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Bus-slave transmit buffer in front of the UART transmitter.
// Firmware writes bytes into a FIFO; an FSM feeds them to the transmitter
// over the sendData/sendReq/ready handshake.
// Ports:
//   clk, rst                       clock, async active-high reset
//   bus_req/we/addr/wdata/be       slave request
//   bus_rdata                      combinational read data
//   tx_data, tx_req                byte and one-cycle send pulse (registered)
//   tx_ready                       transmitter idle
//   irq_o                          low-watermark level interrupt (registered)
module uart_tx_buf
  import uart_tx_buf_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned LOW_WM   = 4,
  parameter int unsigned CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_be,
  output logic [31:0] bus_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_req,
  input  logic        tx_ready,
  output logic        irq_o
);

  logic [1:0]          state;
  logic [1:0]          state_nx;
  logic [TMO_W-1:0]    tmo;
  logic [TMO_W-1:0]    tmo_nx;
  logic [7:0]          tx_data_nx;
  logic                tx_req_nx;
  logic                pop_c;

  logic                overflow;
  logic                irq_en;

  logic                wr_en_c;
  logic                txdata_wr_c;
  logic                ctrl_wr_c;
  logic                flush_c;
  logic                ovf_clr_c;
  logic                dropped_c;

  logic [7:0]          head_c;
  logic                full_c;
  logic                empty_c;
  logic                push_ok_c;
  logic [CNT_BITS-1:0] count;

  logic [31:0]         status_c;
  logic [31:0]         ctrl_rd_c;
  logic                unused_ok;

  // Bus write decode
  assign wr_en_c     = bus_req & bus_we;
  assign txdata_wr_c = wr_en_c & (bus_addr == ADDR_TXDATA) & bus_be[0];
  assign ctrl_wr_c   = wr_en_c & (bus_addr == ADDR_CTRL) & bus_be[0];
  assign flush_c     = ctrl_wr_c & bus_wdata[CTRL_FLUSH];
  assign ovf_clr_c   = ctrl_wr_c & bus_wdata[CTRL_OVF_CLR];
  // A push discarded by a flush is not an overflow
  assign dropped_c   = txdata_wr_c & ~flush_c & ~push_ok_c;

  assign unused_ok   = ^{bus_wdata[31:8], bus_be[3:1]};

  sync_fifo #(
    .DATA_W   (8),
    .DEPTH    (DEPTH),
    .CNT_BITS (CNT_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (txdata_wr_c),
    .push_data (bus_wdata[7:0]),
    .pop       (pop_c),
    .flush     (flush_c),
    .head_c    (head_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .push_ok_c (push_ok_c),
    .count     (count)
  );

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      tmo     <= '0;
      tx_data <= '0;
      tx_req  <= 1'b0;
    end else begin
      state   <= state_nx;
      tmo     <= tmo_nx;
      tx_data <= tx_data_nx;
      tx_req  <= tx_req_nx;
    end
  end

  // FSM next-state and pop decision
  always_comb begin
    state_nx   = state;
    tmo_nx     = tmo;
    tx_data_nx = tx_data;
    tx_req_nx  = 1'b0;
    pop_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty_c && tx_ready) begin
          pop_c      = 1'b1;
          tx_data_nx = head_c;
          tx_req_nx  = 1'b1;
          tmo_nx     = '0;
          state_nx   = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!tx_ready) begin
          state_nx = S_WAIT_DONE;
        end else if (tmo == TMO_W'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never showed busy; treat the byte as sent
          state_nx = S_IDLE;
        end else begin
          tmo_nx = tmo + TMO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Sticky overflow, irq enable and registered interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      // A drop in the same cycle as a clear leaves the flag set
      if (dropped_c)      overflow <= 1'b1;
      else if (ovf_clr_c) overflow <= 1'b0;
      if (ctrl_wr_c) irq_en <= bus_wdata[CTRL_IRQ_EN];
      irq_o <= irq_en & (count <= CNT_BITS'(LOW_WM));
    end
  end

  // Register read mux
  always_comb begin
    status_c = '0;
    status_c[ST_EMPTY]             = empty_c;
    status_c[ST_FULL]              = full_c;
    status_c[ST_OVF]               = overflow;
    status_c[ST_BUSY]              = (state != S_IDLE);
    status_c[ST_IRQ_EN]            = irq_en;
    status_c[ST_COUNT +: CNT_BITS] = count;

    ctrl_rd_c = '0;
    ctrl_rd_c[CTRL_IRQ_EN] = irq_en;

    bus_rdata = '0;
    if (bus_req) begin
      case (bus_addr)
        ADDR_TXDATA, ADDR_STATUS: bus_rdata = status_c;
        ADDR_CTRL:                bus_rdata = ctrl_rd_c;
        default:                  bus_rdata = '0;
      endcase
    end
  end

endmodule
